// File: rtl/up_down_counter_param.sv
// up_down_counter_param: up/down counter with load, programmable step, limits, wrap/saturate and sticky flags
module up_down_counter_param #(
    parameter int WIDTH      = 8,
    parameter int STEP_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [WIDTH-1:0]      data_in,
    input  logic                  counter_on,
    input  logic                  count_up,
    input  logic [STEP_WIDTH-1:0] step,
    input  logic [WIDTH-1:0]      low_limit,
    input  logic [WIDTH-1:0]      high_limit,
    input  logic                  saturate,
    input  logic                  clear_flags,
    output logic [WIDTH-1:0]      count,
    output logic                  at_high,
    output logic                  at_low,
    output logic                  bound_pulse,
    output logic                  overflow_sticky,
    output logic                  underflow_sticky,
    output logic                  cfg_err
);
    logic [WIDTH-1:0]        count_q, count_d;
    logic                    bound_q, bound_d;
    logic                    ovf_q, ovf_d;
    logic                    unf_q, unf_d;
    logic [WIDTH:0]          cnt_x, step_x, lo_x, hi_x, span, sum, wu;
    logic signed [WIDTH+1:0] wd;
    logic                    run, ovf, unf, ovf_ev, unf_ev;
    logic [WIDTH-1:0]        up_next, dn_next;

    assign cnt_x   = {1'b0, count_q};
    assign step_x  = (WIDTH+1)'(step);
    assign lo_x    = {1'b0, low_limit};
    assign hi_x    = {1'b0, high_limit};
    assign span    = hi_x - lo_x + (WIDTH+1)'(1);
    assign sum     = cnt_x + step_x;
    assign wu      = sum - span;
    assign wd      = $signed({1'b0, cnt_x}) - $signed({1'b0, step_x}) + $signed({1'b0, span});
    assign cfg_err = low_limit > high_limit;
    assign run     = counter_on & ~cfg_err & ~load;
    assign ovf     = sum > hi_x;
    assign unf     = cnt_x < lo_x + step_x;
    assign ovf_ev  = run & count_up & ovf;
    assign unf_ev  = run & ~count_up & unf;

    assign count            = count_q;
    assign at_high          = count_q == high_limit;
    assign at_low           = count_q == low_limit;
    assign bound_pulse      = bound_q;
    assign overflow_sticky  = ovf_q;
    assign underflow_sticky = unf_q;

    // next count: load first, then limited up/down step with wrap or clamp at the range edges
    always_comb begin
        up_next = !ovf ? sum[WIDTH-1:0] :
                  saturate ? high_limit :
                  (wu <= hi_x) ? wu[WIDTH-1:0] : low_limit;
        dn_next = !unf ? count_q - WIDTH'(step) :
                  saturate ? low_limit :
                  (wd >= $signed({1'b0, lo_x})) ? wd[WIDTH-1:0] : high_limit;
        count_d = load ? data_in : run ? (count_up ? up_next : dn_next) : count_q;
        bound_d = ovf_ev | unf_ev;
        ovf_d   = (ovf_q & ~clear_flags) | ovf_ev;
        unf_d   = (unf_q & ~clear_flags) | unf_ev;
    end

    // state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            bound_q <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            bound_q <= bound_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end
endmodule

// File: tb/tb_up_down_counter_param.sv
// tb_up_down_counter_param: scoreboard bench with directed and random stimulus against an integer model
module tb_up_down_counter_param;
    localparam int W  = 8;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1, load = 1'b0, counter_on = 1'b0, count_up = 1'b1;
    logic          saturate = 1'b0, clear_flags = 1'b0;
    logic [W-1:0]  data_in = '0, low_limit = '0, high_limit = '1;
    logic [SW-1:0] step = '0;
    logic [W-1:0]  count;
    logic          at_high, at_low, bound_pulse, overflow_sticky, underflow_sticky, cfg_err;

    up_down_counter_param #(.WIDTH(W), .STEP_WIDTH(SW)) dut (
        .clk(clk), .reset(reset), .load(load), .data_in(data_in), .counter_on(counter_on),
        .count_up(count_up), .step(step), .low_limit(low_limit), .high_limit(high_limit),
        .saturate(saturate), .clear_flags(clear_flags), .count(count), .at_high(at_high),
        .at_low(at_low), .bound_pulse(bound_pulse), .overflow_sticky(overflow_sticky),
        .underflow_sticky(underflow_sticky), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int c;
        bit p, o, u, ah, al, ce;
    } exp_t;

    exp_t q[$];
    int   ncmp = 0, nbad = 0;
    int   mc = 0;
    bit   mo = 0, mu = 0;
    bit   done = 0;

    task automatic chk(string n, logic [31:0] a, logic [31:0] e);
        ncmp++;
        if (a !== e) begin
            nbad++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
        end
    endtask

    // Drive one cycle of inputs and push the model's post-edge expectation
    task automatic drive(bit r, bit ld, int d, bit on, bit up, int st, int lo, int hi, bit sat, bit clr);
        exp_t e;
        int   span, s;
        bit   eo, eu;
        @(negedge clk);
        reset = r; load = ld; data_in = W'(d); counter_on = on; count_up = up;
        step = SW'(st); low_limit = W'(lo); high_limit = W'(hi); saturate = sat; clear_flags = clr;
        span = hi - lo + 1;
        eo = 0; eu = 0;
        if (r) begin
            mc = 0; mo = 0; mu = 0;
        end else begin
            if (ld) mc = d;
            else if (on && lo <= hi) begin
                if (up) begin
                    s = mc + st;
                    if (s <= hi) mc = s;
                    else begin
                        eo = 1;
                        mc = sat ? hi : (s - span <= hi ? s - span : lo);
                    end
                end else begin
                    s = mc - st;
                    if (s >= lo) mc = s;
                    else begin
                        eu = 1;
                        mc = sat ? lo : (s + span >= lo ? s + span : hi);
                    end
                end
            end
            mo = (mo && !clr) || eo;
            mu = (mu && !clr) || eu;
        end
        e.c = mc; e.p = eo || eu; e.o = mo; e.u = mu;
        e.ah = (mc == hi); e.al = (mc == lo); e.ce = (lo > hi);
        q.push_back(e);
    endtask

    // Monitor: after every rising edge compare the DUT against the oldest expectation
    initial begin
        exp_t e;
        while (!done) begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("count", 32'(count), 32'(e.c));
                chk("bound_pulse", 32'(bound_pulse), 32'(e.p));
                chk("overflow_sticky", 32'(overflow_sticky), 32'(e.o));
                chk("underflow_sticky", 32'(underflow_sticky), 32'(e.u));
                chk("at_high", 32'(at_high), 32'(e.ah));
                chk("at_low", 32'(at_low), 32'(e.al));
                chk("cfg_err", 32'(cfg_err), 32'(e.ce));
            end
        end
    end

    initial begin
        int lo, hi, st, mode;
        bit sat;
        drive(1, 0, 0, 0, 1, 1, 0, 255, 0, 0);
        drive(1, 1, 99, 1, 1, 1, 0, 255, 0, 0);
        // full range, step 1, wrap
        drive(0, 1, 254, 0, 1, 1, 0, 255, 0, 0);
        repeat (3) drive(0, 0, 0, 1, 1, 1, 0, 255, 0, 0);
        repeat (2) drive(0, 0, 0, 1, 0, 1, 0, 255, 0, 0);
        // 10..20 wrap, step 3 and step larger than span
        drive(0, 1, 19, 0, 1, 3, 10, 20, 0, 1);
        drive(0, 0, 0, 1, 1, 3, 10, 20, 0, 0);
        drive(0, 0, 0, 1, 0, 3, 10, 20, 0, 0);
        drive(0, 0, 0, 1, 1, 15, 10, 20, 0, 0);
        drive(0, 1, 11, 0, 0, 15, 10, 20, 0, 0);
        drive(0, 0, 0, 1, 0, 15, 10, 20, 0, 0);
        // saturate repeated events, then clear with and without an event
        drive(0, 1, 19, 0, 1, 3, 10, 20, 1, 1);
        repeat (3) drive(0, 0, 0, 1, 1, 3, 10, 20, 1, 0);
        drive(0, 0, 0, 1, 1, 3, 10, 20, 1, 1);
        drive(0, 0, 0, 0, 1, 3, 10, 20, 1, 1);
        repeat (2) drive(0, 0, 0, 1, 0, 3, 10, 20, 1, 0);
        // priority
        drive(0, 1, 7, 1, 1, 1, 0, 255, 0, 0);
        drive(1, 1, 9, 1, 1, 1, 0, 255, 0, 0);
        drive(0, 0, 0, 1, 1, 1, 0, 255, 0, 0);
        // out-of-range load, bad configuration
        drive(0, 1, 30, 0, 1, 1, 10, 20, 1, 0);
        drive(0, 0, 0, 1, 1, 1, 10, 20, 1, 0);
        drive(0, 1, 30, 0, 1, 1, 10, 20, 0, 0);
        drive(0, 0, 0, 1, 1, 1, 10, 20, 0, 0);
        drive(0, 1, 3, 0, 0, 2, 10, 20, 0, 0);
        drive(0, 0, 0, 1, 0, 2, 10, 20, 0, 0);
        repeat (2) drive(0, 0, 0, 1, 1, 1, 20, 10, 0, 0);
        drive(0, 1, 5, 1, 1, 1, 20, 10, 0, 0);
        // zero step
        drive(0, 1, 15, 0, 1, 0, 10, 20, 0, 0);
        repeat (4) drive(0, 0, 0, 1, 1, 0, 10, 20, 0, 0);
        // random stimulus with configuration held in stretches
        for (int blk = 0; blk < 60; blk++) begin
            mode = $urandom_range(0, 3);
            lo = $urandom_range(0, 255);
            hi = $urandom_range(0, 255);
            if (mode == 0) begin lo = 0; hi = 255; end
            else if (mode != 3 && lo > hi) begin int t; t = lo; lo = hi; hi = t; end
            sat = $urandom_range(0, 1);
            st = $urandom_range(0, 15);
            for (int i = 0; i < 32; i++)
                drive($urandom_range(0, 63) == 0, $urandom_range(0, 11) == 0, $urandom_range(0, 255),
                      $urandom_range(0, 7) != 0, $urandom_range(0, 1), ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : st,
                      lo, hi, sat, $urandom_range(0, 15) == 0);
        end
        @(posedge clk);
        #3;
        done = 1;
        ncmp++;
        if (q.size() != 0) begin
            nbad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end
endmodule
